ifu: RTL

IFU -- requirements
Module: ifu

---
 rtl/ifu_pkg.sv | 28 ++
 rtl/ifu_pc.sv | 49 ++++
 rtl/ifu.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg -- shared definitions for the instruction fetch unit.
//   RESET_PC_DEFAULT : first fetch address after reset
//   PC_W / INST_W    : pc/register bus width and instruction bus width
//   ifu_state_e      : 2-bit fetch FSM state encoding
//   align4()         : clears the low two bits of an address
// ---------------------------------------------------------------------------
package ifu_pkg;

  localparam int unsigned PC_W   = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // request driven toward instruction memory
    ST_WAIT = 2'd1,  // request accepted, response pending
    ST_OUT  = 2'd2   // instruction held for decode
  } ifu_state_e;

  // Force an address onto a 4-byte boundary.
  function automatic logic [PC_W-1:0] align4(input logic [PC_W-1:0] addr);
    logic [PC_W-1:0] mask;
    mask = {{(PC_W-2){1'b1}}, 2'b00};
    return addr & mask;
  endfunction

endpackage

// File: rtl/ifu_pc.sv
// ---------------------------------------------------------------------------
// ifu_pc -- program counter register of the fetch unit.
//   clk_i         : clock, rising edge
//   rst_i         : synchronous active-high reset, loads RESET_PC
//   redirect_i    : load redirect_pc_i (aligned); beats advance_i
//   redirect_pc_i : redirect target
//   advance_i     : step to the next sequential instruction (pc + 4)
//   pc_o          : current pc
// ---------------------------------------------------------------------------
module ifu_pc
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            advance_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  // Next pc: redirect first, then sequential advance (64-bit wrap), else hold.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = align4(redirect_pc_i);
    end else if (advance_i) begin
      pc_d = pc_q + 64'd4;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- single-outstanding instruction fetch unit.
// Issues one fetch at a time, captures the returned word and presents it to
// decode. Redirects from downstream replace the pc at any time; a response
// already in flight when a redirect occurs is dropped.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   redirect_valid_i/_pc_i       : control-flow redirect and its target
//   imem_req_valid_o/_ready_i    : fetch request handshake
//   imem_req_addr_o              : fetch address (4-byte aligned)
//   imem_rsp_valid_i/_data_i     : fetch response (always accepted)
//   out_valid_o/_ready_i         : handshake toward decode
//   out_pc_o, out_inst_o         : presented instruction and its pc
// ---------------------------------------------------------------------------
module ifu
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_valid_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [PC_W-1:0]   imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   out_pc_o,
  output logic [INST_W-1:0] out_inst_o
);

  ifu_state_e        state_d, state_q;
  logic              drop_d, drop_q;
  logic [INST_W-1:0] inst_d, inst_q;
  logic              req_valid_q;
  logic              out_valid_q;
  logic              pc_advance;
  logic [PC_W-1:0]   pc;

  ifu_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_valid_i),
    .redirect_pc_i (redirect_pc_i),
    .advance_i     (pc_advance),
    .pc_o          (pc)
  );

  // Next-state logic for the fetch FSM, drop flag and instruction buffer.
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    inst_d     = inst_q;
    pc_advance = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (imem_req_ready_i) begin
          state_d = ST_WAIT;
          // A redirect in the acceptance cycle makes the in-flight word stale.
          drop_d  = redirect_valid_i;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid_i) begin
          drop_d = 1'b0;
          if (drop_q || redirect_valid_i) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_OUT;
            inst_d  = imem_rsp_data_i;
          end
        end else if (redirect_valid_i) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      ST_OUT: begin
        // Redirect wins over a decode handshake: no sequential advance.
        if (redirect_valid_i) begin
          state_d = ST_REQ;
        end else if (out_ready_i) begin
          state_d    = ST_REQ;
          pc_advance = 1'b1;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_REQ;
        drop_d  = 1'b0;
      end
    endcase
  end

  // FSM state, drop flag, instruction buffer and registered valid outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_REQ;
      drop_q      <= 1'b0;
      inst_q      <= 32'h0;
      req_valid_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      inst_q      <= inst_d;
      req_valid_q <= (state_d == ST_REQ);
      out_valid_q <= (state_d == ST_OUT);
    end
  end

  assign imem_req_valid_o = req_valid_q;
  assign imem_req_addr_o  = pc;
  assign out_valid_o      = out_valid_q;
  assign out_pc_o         = pc;
  assign out_inst_o       = inst_q;

endmodule
